// File: rtl/scarf_pkg.sv
// Shared definitions for the SCARF block RAM slave: FSM state encoding and
// bus address geometry.
package scarf_pkg;

    localparam int SCARF_ADDR_BYTES = 2;
    localparam int SCARF_LO_BITS    = 8 * (SCARF_ADDR_BYTES - 1);

    localparam logic [7:0] SCARF_PAST_END_BYTE = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ADDR_HI = 2'd1,
        ST_ADDR_LO = 2'd2,
        ST_DATA    = 2'd3
    } scarf_state_e;

endpackage

// File: rtl/bram_sp.sv
// Byte-wide single-port RAM with synchronous read (one-cycle latency).
// A read register holds its value on write cycles.
module bram_sp #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [7:0]            wdata,
    output logic [7:0]            rdata
);

    logic [7:0] mem [2**ADDR_WIDTH];

    // NOTE: neither the array nor the read register is reset; a reset term
    // here would prevent block-RAM inference and would wipe stored data.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/scarf_block_ram.sv
// SCARF bus slave exposing a byte-addressed block RAM (2-byte address, then data).
// Define SCARF_BRAM_ADDR_WRAP_EN to wrap the address at the top; default saturates.
module scarf_block_ram
    import scarf_pkg::*;
#(
    parameter logic [6:0] SLAVE_ID   = 7'd1,
    parameter int         ADDR_WIDTH = 10
) (
    input  logic       clk,
    input  logic       rst_n_sync,
    input  logic [7:0] data_in,
    input  logic       data_in_valid,
    input  logic       data_in_finished,
    input  logic [6:0] slave_id,
    input  logic       rnw,
    output logic [7:0] read_data_out,
    output logic       selected
);

    localparam int HI_BITS = (ADDR_WIDTH > SCARF_LO_BITS) ? ADDR_WIDTH - SCARF_LO_BITS : 1;

    scarf_state_e          state;
    logic [HI_BITS-1:0]    addr_hi;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH-1:0] addr_load;
    logic                  past_end;
    logic                  rd_pending;
    logic                  show_ff;

    logic                  ram_en;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [7:0]            ram_rdata;

    // Address bits beyond the RAM depth are simply never stored.
    generate
        if (ADDR_WIDTH > SCARF_LO_BITS) begin : g_wide
            assign addr_load = {addr_hi, data_in};
        end else begin : g_narrow
            assign addr_load = data_in[ADDR_WIDTH-1:0];
        end
    endgenerate

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            state      <= ST_IDLE;
            addr_hi    <= '0;
            addr       <= '0;
            past_end   <= 1'b0;
            rd_pending <= 1'b0;
            show_ff    <= 1'b0;
        end else begin
            rd_pending <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    past_end <= 1'b0;
                    show_ff  <= 1'b0;
                    if (!data_in_finished && slave_id == SLAVE_ID) begin
                        state <= ST_ADDR_HI;
                    end
                end
                ST_ADDR_HI: begin
                    if (data_in_valid) begin
                        addr_hi <= data_in[HI_BITS-1:0];
                        state   <= ST_ADDR_LO;
                    end
                end
                ST_ADDR_LO: begin
                    if (data_in_valid) begin
                        addr     <= addr_load;
                        past_end <= 1'b0;
                        show_ff  <= 1'b0;
                        state    <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (data_in_valid) begin
                        if (!past_end) begin
`ifdef SCARF_BRAM_ADDR_WRAP_EN
                            addr <= addr + 1'b1;
`else
                            if (&addr) begin
                                past_end <= 1'b1;
                            end else begin
                                addr <= addr + 1'b1;
                            end
`endif
                        end
                        rd_pending <= rnw;
                    end
                    // A refill read that falls off the end reports a filler byte.
                    if (rd_pending && past_end) begin
                        show_ff <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
            if (data_in_finished) begin
                state <= ST_IDLE;
            end
        end
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        ram_en   = 1'b0;
        ram_we   = 1'b0;
        ram_addr = addr;
        if (state == ST_ADDR_LO && data_in_valid) begin
            ram_en   = 1'b1;
            ram_addr = addr_load;
        end else if (state == ST_DATA && data_in_valid && !rnw && !past_end) begin
            ram_en = 1'b1;
            ram_we = 1'b1;
        end else if (rd_pending && !past_end) begin
            ram_en = 1'b1;
        end
    end

    bram_sp #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_bram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (data_in),
        .rdata (ram_rdata)
    );

    assign selected      = (state != ST_IDLE);
    assign read_data_out = !selected ? 8'h00
                         : show_ff   ? SCARF_PAST_END_BYTE
                         :             ram_rdata;

endmodule

// File: tb/tb_scarf_block_ram.sv
// Directed bench for scarf_block_ram: write, read timing, foreign slave,
// address masking, end-of-memory behaviour and mid-cycle reset.
module tb_scarf_block_ram;

    logic       clk = 1'b0;
    logic       rst_n_sync;
    logic [7:0] data_in;
    logic       data_in_valid;
    logic       data_in_finished;
    logic [6:0] slave_id;
    logic       rnw;
    logic [7:0] read_data_out;
    logic       selected;

    int total = 0;
    int bad   = 0;

    scarf_block_ram dut (
        .clk              (clk),
        .rst_n_sync       (rst_n_sync),
        .data_in          (data_in),
        .data_in_valid    (data_in_valid),
        .data_in_finished (data_in_finished),
        .slave_id         (slave_id),
        .rnw              (rnw),
        .read_data_out    (read_data_out),
        .selected         (selected)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_cycle(input logic [7:0] id);
        data_in_finished = 1'b0;
        slave_id         = id[6:0];
        rnw              = id[7];
        tick();
    endtask

    task automatic send(input logic [7:0] b);
        data_in       = b;
        data_in_valid = 1'b1;
        tick();
        data_in_valid = 1'b0;
    endtask

    task automatic finish_cycle();
        data_in_finished = 1'b1;
        tick();
    endtask

    task automatic write_byte(input logic [15:0] a, input logic [7:0] d);
        start_cycle(8'h01);
        send(a[15:8]);
        send(a[7:0]);
        send(d);
        finish_cycle();
    endtask

    task automatic read_byte(input logic [15:0] a, output logic [7:0] d);
        start_cycle(8'h81);
        send(a[15:8]);
        send(a[7:0]);
        d = read_data_out;
        finish_cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] rd;

        rst_n_sync       = 1'b0;
        data_in          = 8'h00;
        data_in_valid    = 1'b0;
        data_in_finished = 1'b1;
        slave_id         = 7'd0;
        rnw              = 1'b0;
        tick();
        tick();
        check("reset_selected", {7'd0, selected}, 8'h00);
        check("reset_rdata", read_data_out, 8'h00);
        rst_n_sync = 1'b1;
        tick();
        check("post_reset_selected", {7'd0, selected}, 8'h00);

        // Write A5, 5A to 0x0010
        start_cycle(8'h01);
        check("wr_sel_addr_hi", {7'd0, selected}, 8'h01);
        send(8'h00);
        check("wr_sel_addr_lo", {7'd0, selected}, 8'h01);
        send(8'h10);
        send(8'hA5);
        send(8'h5A);
        check("wr_sel_data", {7'd0, selected}, 8'h01);
        finish_cycle();
        check("wr_sel_after", {7'd0, selected}, 8'h00);
        check("wr_rdata_after", read_data_out, 8'h00);

        // Read back with two dummies and cycle-exact timing
        start_cycle(8'h81);
        send(8'h00);
        send(8'h10);
        check("rd_first", read_data_out, 8'hA5);
        data_in       = 8'h00;
        data_in_valid = 1'b1;
        check("rd_strobe_cycle", read_data_out, 8'hA5);
        tick();
        data_in_valid = 1'b0;
        check("rd_strobe_plus1", read_data_out, 8'hA5);
        tick();
        check("rd_strobe_plus2", read_data_out, 8'h5A);
        send(8'h00);
        check("rd_second_dummy_plus1", read_data_out, 8'h5A);
        finish_cycle();
        check("rd_sel_after", {7'd0, selected}, 8'h00);
        check("rd_rdata_after", read_data_out, 8'h00);

        // Foreign slave must not touch memory or outputs
        start_cycle(8'h02);
        check("other_sel", {7'd0, selected}, 8'h00);
        send(8'h00);
        send(8'h10);
        send(8'hFF);
        check("other_sel_data", {7'd0, selected}, 8'h00);
        check("other_rdata", read_data_out, 8'h00);
        finish_cycle();
        read_byte(16'h0010, rd);
        check("other_mem16", rd, 8'hA5);

        // Upper address bits beyond ADDR_WIDTH are discarded
        start_cycle(8'h01);
        send(8'hFC);
        send(8'h05);
        send(8'h3C);
        finish_cycle();
        read_byte(16'h0005, rd);
        check("mask_mem5", rd, 8'h3C);

        // End of memory
        write_byte(16'h0000, 8'h77);
        start_cycle(8'h01);
        send(8'h03);
        send(8'hFF);
        send(8'h11);
        send(8'h22);
        finish_cycle();
        read_byte(16'h03FF, rd);
        check("bound_mem1023", rd, 8'h11);
        read_byte(16'h0000, rd);
`ifdef SCARF_BRAM_ADDR_WRAP_EN
        check("bound_mem0", rd, 8'h22);
`else
        check("bound_mem0", rd, 8'h77);
`endif
        start_cycle(8'h81);
        send(8'h03);
        send(8'hFF);
        check("pastend_first", read_data_out, 8'h11);
        data_in       = 8'h00;
        data_in_valid = 1'b1;
        check("pastend_strobe", read_data_out, 8'h11);
        tick();
        data_in_valid = 1'b0;
        check("pastend_plus1", read_data_out, 8'h11);
        tick();
`ifdef SCARF_BRAM_ADDR_WRAP_EN
        check("pastend_plus2", read_data_out, 8'h22);
`else
        check("pastend_plus2", read_data_out, 8'hFF);
`endif
        finish_cycle();

        // Reset in the middle of a 3-byte write
        write_byte(16'h0020, 8'hC0);
        write_byte(16'h0021, 8'hC1);
        write_byte(16'h0022, 8'hC2);
        start_cycle(8'h01);
        send(8'h00);
        send(8'h20);
        send(8'h31);
        rst_n_sync = 1'b0;
        #1;
        check("rst_mid_selected", {7'd0, selected}, 8'h00);
        check("rst_mid_rdata", read_data_out, 8'h00);
        data_in_finished = 1'b1;
        data_in          = 8'h32;
        data_in_valid    = 1'b1;
        tick();
        data_in_valid = 1'b0;
        rst_n_sync    = 1'b1;
        tick();
        read_byte(16'h0020, rd);
        check("rst_mem20", rd, 8'h31);
        read_byte(16'h0021, rd);
        check("rst_mem21", rd, 8'hC1);
        read_byte(16'h0022, rd);
        check("rst_mem22", rd, 8'hC2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/scarf_block_ram.md
SCARF_BLOCK_RAM -- requirements
Module: scarf_block_ram

Interface
REQ-001 SHALL have parameter SLAVE_ID, default 7'd1: slave select value this block answers to.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10: memory depth 2**ADDR_WIDTH bytes; legal range 1..16.
REQ-003 SHALL have port clk  input  1  fpga clock; sole clock.
REQ-004 SHALL have port rst_n_sync  input  1  reset, asynchronous, active-low; already synchronized to clk upstream.
REQ-005 SHALL have port data_in  input  8  received byte, clk domain.
REQ-006 SHALL have port data_in_valid  input  1  one-cycle strobe, data_in valid; never asserted for the slave-id byte.
REQ-007 SHALL have port data_in_finished  input  1  high between bus cycles; falls in the cycle slave_id/rnw update.
REQ-008 SHALL have port slave_id  input  7  slave select of current bus cycle.
REQ-009 SHALL have port rnw  input  1  1 = read cycle, 0 = write cycle.
REQ-010 SHALL have port read_data_out  output  8  byte returned to UART transmitter.
REQ-011 SHALL have port selected  output  1  high while this block owns the current bus cycle.

Function
REQ-012 SHALL implement FSM states IDLE, ADDR_HI, ADDR_LO, DATA.
REQ-013 IDLE -> ADDR_HI SHALL occur in the cycle after data_in_finished is low with slave_id == SLAVE_ID; otherwise stay IDLE.
REQ-014 ADDR_HI SHALL capture data_in into address bits [15:8] on data_in_valid, then -> ADDR_LO.
REQ-015 ADDR_LO SHALL capture data_in into address bits [7:0] on data_in_valid, issue a RAM read of that address, then -> DATA.
REQ-016 Address bits at or above ADDR_WIDTH SHALL be discarded.
REQ-017 DATA with rnw=0: each data_in_valid SHALL write data_in to mem[addr] in that cycle, then increment addr.
REQ-018 DATA with rnw=1: each data_in_valid byte (dummy) SHALL leave read_data_out unchanged in that cycle and the next; addr increments; read_data_out SHALL show mem[new addr] exactly 2 cycles after the strobe.
REQ-019 read_data_out SHALL show mem[start addr] no later than 2 cycles after the ADDR_LO strobe.
REQ-020 Any state SHALL return to IDLE in the cycle after data_in_finished is high; a strobe in that same cycle SHALL still be processed.
REQ-021 selected SHALL be high in ADDR_HI, ADDR_LO and DATA; low in IDLE.
REQ-022 read_data_out SHALL be 8'h00 whenever selected is low.
REQ-023 Memory SHALL be single-port, synchronous read, 1-cycle latency; no read and write to the RAM in the same cycle.
REQ-024 Bus cycles addressed to another slave_id SHALL produce no memory access and no output change.

Reset
REQ-025 On rst_n_sync low: state IDLE, addr 0, read_data_out 8'h00, selected 0, all immediately (asynchronous).
REQ-026 Memory contents SHALL NOT be reset; reset mid-write SHALL leave completed writes intact and drop the pending byte.

Configuration
REQ-027 With macro SCARF_BRAM_ADDR_WRAP_EN defined, addr SHALL wrap from 2**ADDR_WIDTH-1 to 0.
REQ-028 Without SCARF_BRAM_ADDR_WRAP_EN, addr SHALL saturate past the last location: further writes dropped, read_data_out 8'hFF for past-end reads.

Structure
REQ-029 Package scarf_pkg SHALL hold the FSM state enum and constant SCARF_ADDR_BYTES = 2.
REQ-030 Storage SHALL be a sub-module bram_sp (single-port, sync read, byte-wide, parameterized depth) so synthesis infers block RAM.

Verification
REQ-031 Write: id 8'h01, addr 8'h00 8'h10, data 8'hA5 8'h5A -> mem[16]=A5, mem[17]=5A, selected high throughout, low after finished.
REQ-032 Read: id 8'h81, addr 00 10, 2 dummies -> read_data_out A5 within 2 cycles of addr-low strobe, 5A 2 cycles after first dummy, stable in the strobe cycle and the next.
REQ-033 Other slave: id 8'h02, addr 00 10, data FF -> mem[16] unchanged, selected 0, read_data_out 00.
REQ-034 Boundary: ADDR_WIDTH=10, write at addr 03FF then 2 bytes 11, 22 -> with WRAP_EN mem[1023]=11, mem[0]=22; without, mem[0] unchanged.
REQ-035 Reset mid-cycle: assert rst_n_sync after first data byte of a 3-byte write -> state IDLE immediately, first byte kept, rest absent.
REQ-036 Address masking: write addr FC 05 with ADDR_WIDTH=10 -> byte lands at mem[0x005].
